// File: rtl/apb_bus_arbiter.sv
// Two-requester round-robin arbiter in front of a single APB master port.
// Optional build macro APB_ARB_TIMEOUT_EN adds a WAIT-state timeout that forces an error completion.
module apb_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,

    input  logic        m0_transfer,
    input  logic        m0_write,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_ready,
    output logic        m0_err,

    input  logic        m1_transfer,
    input  logic        m1_write,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_ready,
    output logic        m1_err,

    output logic        s_transfer,
    output logic        s_write,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,
    input  logic        s_ready,

    output logic        owner
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t      state_q;
    logic        s_transfer_q;
    logic        s_write_q;
    logic [31:0] s_addr_q;
    logic [31:0] s_wdata_q;
    logic        owner_q;
    logic        last_q;

    logic        grant_d;
    logic        done_ok;
    logic        timeout_hit;
    logic        complete;

    // On a tie the requester that was not served last wins.
    always_comb begin
        grant_d = 1'b0;
        if (m0_transfer && m1_transfer) begin
            grant_d = ~last_q;
        end else if (m1_transfer) begin
            grant_d = 1'b1;
        end
    end

    assign done_ok = (state_q == WAIT) && s_ready && !PRESET;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    assign timeout_hit = (state_q == WAIT) && !s_ready && (cnt_q == CNT_MAX) && !PRESET;
    assign m0_err      = timeout_hit && !owner_q;
    assign m1_err      = timeout_hit &&  owner_q;
`else
    assign timeout_hit = 1'b0;
    assign m0_err      = 1'b0;
    assign m1_err      = 1'b0;
`endif

    assign complete = done_ok || timeout_hit;

    // NOTE: ready/rdata are combinational from s_ready/s_rdata so the requester sees completion in the same cycle.
    assign m0_ready = complete && !owner_q;
    assign m1_ready = complete &&  owner_q;
    assign m0_rdata = (done_ok && !owner_q) ? s_rdata : 32'h0;
    assign m1_rdata = (done_ok &&  owner_q) ? s_rdata : 32'h0;

    assign s_transfer = s_transfer_q;
    assign s_write    = s_write_q;
    assign s_addr     = s_addr_q;
    assign s_wdata    = s_wdata_q;
    assign owner      = owner_q;

    // NOTE: all state is written with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q      <= IDLE;
            s_transfer_q <= 1'b0;
            s_write_q    <= 1'b0;
            s_addr_q     <= 32'h0;
            s_wdata_q    <= 32'h0;
            owner_q      <= 1'b0;
            last_q       <= 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
            cnt_q        <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (m0_transfer || m1_transfer) begin
                        owner_q      <= grant_d;
                        s_write_q    <= grant_d ? m1_write : m0_write;
                        s_addr_q     <= grant_d ? m1_addr  : m0_addr;
                        s_wdata_q    <= grant_d ? m1_wdata : m0_wdata;
                        s_transfer_q <= 1'b1;
                        state_q      <= START;
                    end
                end
                START: begin
                    s_transfer_q <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
                    cnt_q        <= '0;
`endif
                    state_q      <= WAIT;
                end
                WAIT: begin
                    if (complete) begin
                        last_q  <= owner_q;
                        state_q <= IDLE;
                    end
`ifdef APB_ARB_TIMEOUT_EN
                    else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
`endif
                end
                default: begin
                    state_q      <= IDLE;
                    s_transfer_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
